test_harness: RTL and testbench



---
 rtl/test_harness.sv | 149 ++++++++++++++
 tb/tb_test_harness.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/test_harness.sv
// test_harness: self-checking bring-up harness. After reset release it runs a
// March C- BIST over an internal single-port synchronous RAM. It raises a
// sticky success flag only if every element completes without a mismatch.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous active-low reset (0 = in reset)
//   io_success - registered; high once the March C- run finished cleanly
module test_harness #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned WIDTH      = 8,
  parameter int          FAULT_ADDR = -1,
  parameter int unsigned FAULT_BIT  = 0
) (
  input  logic clock,
  input  logic reset,
  output logic io_success
);

  localparam int unsigned      AW         = $clog2(DEPTH);
  localparam logic [AW-1:0]    ADDR_LAST  = AW'(DEPTH - 1);
  localparam bit               FAULT_EN   = (FAULT_ADDR >= 0);
  localparam logic [AW-1:0]    FAULT_A    = AW'(FAULT_EN ? FAULT_ADDR : 0);
  localparam logic [WIDTH-1:0] FAULT_MASK = WIDTH'(1) << FAULT_BIT;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_M0   = 4'd1;
  localparam logic [3:0] S_M1   = 4'd2;
  localparam logic [3:0] S_M2   = 4'd3;
  localparam logic [3:0] S_M3   = 4'd4;
  localparam logic [3:0] S_M4   = 4'd5;
  localparam logic [3:0] S_M5   = 4'd6;
  localparam logic [3:0] S_DONE = 4'd7;
  localparam logic [3:0] S_FAIL = 4'd8;

  logic [3:0]       r_state;
  logic [AW-1:0]    r_addr;
  logic             r_phase;     // 0 = read-issue cycle, 1 = compare/write cycle
  logic             r_success;
  logic [WIDTH-1:0] r_rdata;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [3:0]       w_next_state;
  logic [AW-1:0]    w_next_addr;
  logic             w_next_phase;
  logic             w_we;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_expect;
  logic             w_up;
  logic             w_has_rd;
  logic             w_has_wr;
  logic [3:0]       w_elem_next;
  logic [AW-1:0]    w_next_first;
  logic             w_last;
  logic [WIDTH-1:0] w_rdata_chk;
  logic             w_mismatch;

  // March element descriptor for the current state
  always_comb begin
    w_up        = 1'b1;
    w_has_rd    = 1'b0;
    w_has_wr    = 1'b0;
    w_expect    = '0;
    w_wdata     = '0;
    w_elem_next = S_FAIL;
    case (r_state)
      S_M0: begin w_has_wr = 1'b1; w_elem_next = S_M1; end
      S_M1: begin
        w_has_rd = 1'b1; w_has_wr = 1'b1; w_wdata = '1; w_elem_next = S_M2;
      end
      S_M2: begin
        w_has_rd = 1'b1; w_has_wr = 1'b1; w_expect = '1; w_elem_next = S_M3;
      end
      S_M3: begin
        w_up = 1'b0; w_has_rd = 1'b1; w_has_wr = 1'b1; w_wdata = '1;
        w_elem_next = S_M4;
      end
      S_M4: begin
        w_up = 1'b0; w_has_rd = 1'b1; w_has_wr = 1'b1; w_expect = '1;
        w_elem_next = S_M5;
      end
      S_M5: begin w_has_rd = 1'b1; w_elem_next = S_DONE; end
      default: ;
    endcase
  end

  // Down elements start at the top address, up elements at zero
  assign w_next_first = (w_elem_next == S_M3 || w_elem_next == S_M4) ? ADDR_LAST : '0;
  assign w_last       = w_up ? (r_addr == ADDR_LAST) : (r_addr == '0);
  // Optional stuck-at-1 fault on the read path of one address
  assign w_rdata_chk  = r_rdata | ((FAULT_EN && (r_addr == FAULT_A)) ? FAULT_MASK : '0);
  assign w_mismatch   = w_has_rd && r_phase && (w_rdata_chk != w_expect);

  // Next-state, address sequencing and write enable
  always_comb begin
    w_next_state = r_state;
    w_next_addr  = r_addr;
    w_next_phase = 1'b0;
    w_we         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_state = S_M0;
        w_next_addr  = '0;
      end
      S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
        if (w_has_rd && !r_phase) begin
          w_next_phase = 1'b1;
        end else if (w_mismatch) begin
          w_next_state = S_FAIL;
        end else begin
          w_we = w_has_wr;
          if (w_last) begin
            w_next_state = w_elem_next;
            w_next_addr  = w_next_first;
          end else begin
            w_next_addr = w_up ? r_addr + 1'b1 : r_addr - 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Control state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_phase   <= 1'b0;
      r_success <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_addr    <= w_next_addr;
      r_phase   <= w_next_phase;
      r_success <= (w_next_state == S_DONE);
    end
  end

  // Single-port RAM: synchronous write, registered read
  always_ff @(posedge clock) begin
    if (w_we) begin
      r_mem[r_addr] <= w_wdata;
    end
    r_rdata <= r_mem[r_addr];
  end

  assign io_success = r_success;

endmodule

// File: tb/tb_test_harness.sv
// tb_test_harness: directed bench for test_harness. Four instances share one
// clock: clean default, two fault-injected variants and a DEPTH=4 instance
// whose write trace is recorded.
module tb_test_harness;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_x;
  logic io_a, io_b, io_c, io_d;

  test_harness #(.DEPTH(256), .WIDTH(8), .FAULT_ADDR(-1), .FAULT_BIT(0))
    dut_a (.clock(clk), .reset(rst_a), .io_success(io_a));
  test_harness #(.DEPTH(256), .WIDTH(8), .FAULT_ADDR(5), .FAULT_BIT(3))
    dut_b (.clock(clk), .reset(rst_x), .io_success(io_b));
  test_harness #(.DEPTH(256), .WIDTH(8), .FAULT_ADDR(255), .FAULT_BIT(7))
    dut_c (.clock(clk), .reset(rst_x), .io_success(io_c));
  test_harness #(.DEPTH(4), .WIDTH(4), .FAULT_ADDR(-1), .FAULT_BIT(0))
    dut_d (.clock(clk), .reset(rst_x), .io_success(io_d));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Edge counting since release and first-rise tracking
  int cnt_a = 0, rise_a = 0, cnt_x = 0, rise_d = 0;
  bit seen_a = 0, drop_a = 0, seen_b = 0, seen_c = 0, seen_d = 0;
  int wr_addr[$];
  int wr_data[$];

  always @(negedge rst_a) begin
    cnt_a  = 0;
    seen_a = 0;
    rise_a = 0;
  end

  always @(negedge clk) begin
    if (rst_a) begin
      cnt_a++;
      if (io_a && !seen_a) begin
        seen_a = 1;
        rise_a = cnt_a;
      end else if (!io_a && seen_a) begin
        drop_a = 1;
      end
    end
    if (rst_x) begin
      cnt_x++;
      if (io_b) seen_b = 1;
      if (io_c) seen_c = 1;
      if (io_d && !seen_d) begin
        seen_d = 1;
        rise_d = cnt_x;
      end
      if (dut_d.w_we) begin
        wr_addr.push_back(int'(dut_d.r_addr));
        wr_data.push_back(int'(dut_d.w_wdata));
      end
    end
  end

  typedef struct {
    int   edge_n;
    logic a, b, c, d;
  } vec_t;

  vec_t vecs[10];
  int   cur;
  int   exp_addr, exp_data;

  initial begin
    vecs[0] = '{1,    1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2,    1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{44,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{45,   1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{46,   1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{769,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{770,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{2816, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{2817, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{3500, 1'b1, 1'b0, 1'b0, 1'b1};

    rst_a = 1'b1;
    rst_x = 1'b1;
    #1;
    rst_a = 1'b0;
    rst_x = 1'b0;
    #199;
    check("reset_a", io_a, 0);
    check("reset_b", io_b, 0);
    check("reset_c", io_c, 0);
    check("reset_d", io_d, 0);
    #1;
    rst_a = 1'b1;
    rst_x = 1'b1;
    cur   = 0;

    foreach (vecs[i]) begin
      repeat (vecs[i].edge_n - cur) @(posedge clk);
      cur = vecs[i].edge_n;
      #1;
      check($sformatf("edge%0d_a", cur), io_a, vecs[i].a);
      check($sformatf("edge%0d_b", cur), io_b, vecs[i].b);
      check($sformatf("edge%0d_c", cur), io_c, vecs[i].c);
      check($sformatf("edge%0d_d", cur), io_d, vecs[i].d);
    end
    check("first_rise_a", rise_a, 2817);
    check("first_rise_d", rise_d, 45);

    // Short reset pulse between edges while in DONE
    @(negedge clk);
    #2 rst_a = 1'b0;
    #1 check("async_clear", io_a, 0);
    #1 rst_a = 1'b1;
    repeat (2900) @(negedge clk);
    check("pulse_rerun_seen", seen_a, 1);
    check("pulse_rerun_rise", rise_a, 2817);

    // Fresh run, then a 3-cycle reset at edge 1000
    @(negedge clk);
    #1 rst_a = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_a = 1'b1;
    repeat (1000) @(posedge clk);
    #1 check("edge1000_low", io_a, 0);
    @(negedge clk);
    #1 rst_a = 1'b0;
    #1 check("midreset_low", io_a, 0);
    repeat (3) @(negedge clk);
    #1 rst_a = 1'b1;
    repeat (2900) @(negedge clk);
    check("midreset_rise", rise_a, 2817);
    check("midreset_final", io_a, 1);
    check("no_drop_a", drop_a, 0);

    check("never_b", seen_b, 0);
    check("never_c", seen_c, 0);

    // DEPTH=4 write trace: M0..M2 up, M3..M4 down; data 0,F,0,F,0
    check("trace_len", wr_addr.size(), 20);
    if (wr_addr.size() == 20) begin
      for (int e = 0; e < 5; e++) begin
        for (int k = 0; k < 4; k++) begin
          exp_addr = (e >= 3) ? 3 - k : k;
          exp_data = (e == 1 || e == 3) ? 15 : 0;
          check($sformatf("trace_addr_e%0d_%0d", e, k), wr_addr[e*4+k], exp_addr);
          check($sformatf("trace_data_e%0d_%0d", e, k), wr_data[e*4+k], exp_data);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
